// File: rtl/draw_arbiter.sv
// Arbitrates the single sprite draw engine between N_REQ requesters: latches the
// winner's command, launches the engine, waits for completion (or a timeout) and acks.
module draw_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 65535,
  parameter bit URGENT0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_x,
  input  logic [7*N_REQ-1:0]   req_y,
  input  logic [2*N_REQ-1:0]   req_sprite,
  input  logic [N_REQ-1:0]     req_erase,
  input  logic                 eng_done,
  input  logic                 err_clr,
  output logic                 eng_start,
  output logic [7:0]           eng_x,
  output logic [6:0]           eng_y,
  output logic [1:0]           eng_sprite,
  output logic                 eng_erase,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     ack,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [2:0]           err_id
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [IW-1:0]     ptr_r, owner_r;
  logic [CW-1:0]     cnt_r;
  logic [N_REQ-1:0]  grant_r, ack_r;
  logic              eng_start_r, eng_erase_r, busy_r, timeout_err_r;
  logic [7:0]        eng_x_r;
  logic [6:0]        eng_y_r;
  logic [1:0]        eng_sprite_r;
  logic [2:0]        err_id_r;

  logic              any_req_s, found_s, hit_s, timeout_hit_s;
  logic [IW-1:0]     idx_s, rr_win_s, win_s;
  logic [7:0]        sel_x_s;
  logic [6:0]        sel_y_s;
  logic [1:0]        sel_sprite_s;
  logic              sel_erase_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin search upward from the pointer; wrap by compare so odd N_REQ works.
  always_comb begin
    any_req_s = |req;
    found_s   = 1'b0;
    hit_s     = 1'b0;
    rr_win_s  = IDX_ZERO;
    idx_s     = ptr_r;
    for (int k = 0; k < N_REQ; k++) begin
      hit_s    = ~found_s & req[idx_s];
      rr_win_s = hit_s ? idx_s : rr_win_s;
      found_s  = found_s | hit_s;
      idx_s    = (idx_s == IDX_LAST) ? IDX_ZERO : idx_s + IW'(1);
    end
    win_s = (URGENT0 && req[0]) ? IDX_ZERO : rr_win_s;
  end

  // Select the winner's packed command fields.
  always_comb begin
    sel_x_s      = 8'd0;
    sel_y_s      = 7'd0;
    sel_sprite_s = 2'd0;
    sel_erase_s  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_x_s      = sel_x_s      | (req_x[8*i +: 8]      & {8{win_s == IW'(i)}});
      sel_y_s      = sel_y_s      | (req_y[7*i +: 7]      & {7{win_s == IW'(i)}});
      sel_sprite_s = sel_sprite_s | (req_sprite[2*i +: 2] & {2{win_s == IW'(i)}});
      sel_erase_s  = sel_erase_s  | (req_erase[i]         & (win_s == IW'(i)));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; completion beats timeout when both land together.
  always_comb begin
    state_nxt_s   = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          state_nxt_s = ST_ACK;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s   = ST_ACK;
          timeout_hit_s = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ACK:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered outputs, ownership, round-robin pointer and watchdog counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_start_r   <= 1'b0;
      eng_x_r       <= 8'd0;
      eng_y_r       <= 7'd0;
      eng_sprite_r  <= 2'd0;
      eng_erase_r   <= 1'b0;
      grant_r       <= {N_REQ{1'b0}};
      ack_r         <= {N_REQ{1'b0}};
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      err_id_r      <= 3'd0;
      owner_r       <= IDX_ZERO;
      ptr_r         <= IDX_ZERO;
      cnt_r         <= {CW{1'b0}};
    end else begin
      eng_start_r <= (state_nxt_s == ST_ISSUE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      ack_r       <= (state_nxt_s == ST_ACK) ? onehot(owner_r) : {N_REQ{1'b0}};
      if (state_r == ST_IDLE && any_req_s) begin
        owner_r      <= win_s;
        grant_r      <= onehot(win_s);
        eng_x_r      <= sel_x_s;
        eng_y_r      <= sel_y_s;
        eng_sprite_r <= sel_sprite_s;
        eng_erase_r  <= sel_erase_s;
      end
      if (state_r == ST_ACK) begin
        grant_r <= {N_REQ{1'b0}};
        ptr_r   <= (owner_r == IDX_LAST) ? IDX_ZERO : owner_r + IW'(1);
      end
      if (state_r == ST_ISSUE) begin
        cnt_r <= {CW{1'b0}};
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (timeout_hit_s) begin
        timeout_err_r <= 1'b1;
        err_id_r      <= 3'(owner_r);
      end else if (err_clr) begin
        timeout_err_r <= 1'b0;
      end
    end
  end

  assign eng_start   = eng_start_r;
  assign eng_x       = eng_x_r;
  assign eng_y       = eng_y_r;
  assign eng_sprite  = eng_sprite_r;
  assign eng_erase   = eng_erase_r;
  assign grant       = grant_r;
  assign ack         = ack_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;
  assign err_id      = err_id_r;

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: expected grants are queued when requests are
// driven and compared when the DUT launches the engine and acknowledges.
module tb_draw_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [8*N-1:0]  req_x;
  logic [7*N-1:0]  req_y;
  logic [2*N-1:0]  req_sprite;
  logic [N-1:0]    req_erase;
  logic            eng_done;
  logic            err_clr;
  logic            eng_start;
  logic [7:0]      eng_x;
  logic [6:0]      eng_y;
  logic [1:0]      eng_sprite;
  logic            eng_erase;
  logic [N-1:0]    grant;
  logic [N-1:0]    ack;
  logic            busy;
  logic            timeout_err;
  logic [2:0]      err_id;

  typedef struct {
    int id;
    int lat;
    bit to;
    int st;
  } exp_t;

  exp_t exp_q[$];
  exp_t ack_q[$];

  logic [7:0] x_t  [N];
  logic [6:0] y_t  [N];
  logic [1:0] sp_t [N];
  logic       er_t [N];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int dly_cfg = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  draw_arbiter #(.N_REQ(N), .TIMEOUT(TO), .URGENT0(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_x(req_x), .req_y(req_y),
    .req_sprite(req_sprite), .req_erase(req_erase), .eng_done(eng_done),
    .err_clr(err_clr), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_sprite(eng_sprite), .eng_erase(eng_erase), .grant(grant), .ack(ack),
    .busy(busy), .timeout_err(timeout_err), .err_id(err_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic push_exp(input int id, input int d);
    exp_t e;
    e.id  = id;
    e.to  = (d == 0);
    e.lat = (d == 0) ? TO + 1 : d + 1;
    e.st  = 0;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_start"}, eng_start, 0);
    check_eq({pfx, "_x"}, eng_x, 0);
    check_eq({pfx, "_y"}, eng_y, 0);
    check_eq({pfx, "_sprite"}, eng_sprite, 0);
    check_eq({pfx, "_erase"}, eng_erase, 0);
    check_eq({pfx, "_grant"}, grant, 0);
    check_eq({pfx, "_ack"}, ack, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_terr"}, timeout_err, 0);
    check_eq({pfx, "_errid"}, err_id, 0);
  endtask

  // Wait (bounded) for n acks; drop each acked requester unless hold is set.
  task automatic run_acks(input int n, input bit hold, input bit chk_busy, input int budget);
    int got = 0;
    int cycles = 0;
    while (got < n && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (chk_busy) check_eq("busy_during_op", busy, 1);
      if (ack != '0) begin
        got++;
        if (!hold) req = req & ~ack;
      end
    end
    if (hold) req = '0;
    check_eq("acks_seen", got, n);
  endtask

  // Engine model: pulse eng_done dly_cfg cycles after a launch (0 = never).
  initial begin
    int d;
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && eng_start === 1'b1 && dly_cfg != 0) begin
        d = dly_cfg;
        repeat (d) @(posedge clk);
        #1 eng_done = 1'b1;
        @(posedge clk);
        #1 eng_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor: compare launches and acks against queued expectations.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (eng_start === 1'b1) begin
          if (exp_q.size() == 0) begin
            check_eq("start_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("grant", grant, 32'(1) << e.id);
            check_eq("eng_x", eng_x, x_t[e.id]);
            check_eq("eng_y", eng_y, y_t[e.id]);
            check_eq("eng_sprite", eng_sprite, sp_t[e.id]);
            check_eq("eng_erase", eng_erase, er_t[e.id]);
            e.st = cyc;
            ack_q.push_back(e);
          end
        end
        if (ack !== '0) begin
          if (ack_q.size() == 0) begin
            check_eq("ack_spurious", ack, 0);
          end else begin
            a = ack_q.pop_front();
            check_eq("ack_onehot", ack, 32'(1) << a.id);
            check_eq("ack_latency", cyc - a.st, a.lat);
            check_eq("eng_x_stable", eng_x, x_t[a.id]);
            check_eq("timeout_err", timeout_err, a.to);
            if (a.to) check_eq("err_id", err_id, a.id);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    x_t  = '{8'h05, 8'h9F, 8'h50, 8'hA0};
    y_t  = '{7'h01, 7'h77, 7'h3C, 7'h55};
    sp_t = '{2'd0, 2'd3, 2'd1, 2'd2};
    er_t = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < N; i++) begin
      req_x[8*i +: 8]      = x_t[i];
      req_y[7*i +: 7]      = y_t[i];
      req_sprite[2*i +: 2] = sp_t[i];
      req_erase[i]         = er_t[i];
    end
    req     = '0;
    err_clr = 1'b0;
    reset_n = 1'b0;
    #23;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Fairness: 1110 held, engine done 2 cycles after start.
    repeat (2) @(negedge clk);
    dly_cfg = 2;
    push_exp(1, 2); push_exp(2, 2); push_exp(3, 2);
    push_exp(1, 2); push_exp(2, 2); push_exp(3, 2);
    req = 4'b1110;
    run_acks(6, 1'b1, 1'b0, 100);

    // Single request from 2, done 5 cycles after start, busy window.
    repeat (2) @(negedge clk);
    check_eq("busy_idle", busy, 0);
    dly_cfg = 5;
    push_exp(2, 5);
    req = 4'b0100;
    run_acks(1, 1'b0, 1'b1, 40);
    @(negedge clk);
    check_eq("busy_after", busy, 0);
    check_eq("grant_after", grant, 0);
    check_eq("eng_x_held", eng_x, 8'h50);
    check_eq("eng_y_held", eng_y, 7'h3C);

    // Requester 3 in progress, then 0 and 1 arrive during WAIT.
    repeat (2) @(negedge clk);
    push_exp(3, 5); push_exp(0, 5); push_exp(1, 5);
    req = 4'b1000;
    repeat (3) @(negedge clk);
    req = req | 4'b0011;
    run_acks(3, 1'b0, 1'b0, 80);

    // Timeout: engine never completes.
    repeat (2) @(negedge clk);
    dly_cfg = 0;
    push_exp(1, 0);
    req = 4'b0010;
    run_acks(1, 1'b0, 1'b0, 60);
    @(negedge clk);
    check_eq("terr_sticky", timeout_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("terr_cleared", timeout_err, 0);
    check_eq("err_id_kept", err_id, 1);

    // Done in the same cycle the counter hits its limit: no error.
    repeat (2) @(negedge clk);
    dly_cfg = TO;
    push_exp(2, TO);
    req = 4'b0100;
    run_acks(1, 1'b0, 1'b0, 60);

    // Reset during WAIT; afterwards arbitration restarts from pointer 0.
    repeat (2) @(negedge clk);
    dly_cfg = 0;
    push_exp(3, 0);
    req = 4'b1010;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    exp_q.delete();
    ack_q.delete();
    dly_cfg = 3;
    push_exp(1, 3);
    push_exp(3, 3);
    @(negedge clk);
    check_eq("midreset_ack", ack, 0);
    reset_n = 1'b1;
    run_acks(2, 1'b0, 1'b0, 60);
    check_eq("queue_drained", exp_q.size() + ack_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
